dmr_fault_ctrl: RTL and testbench

//  Consumes the lockstep mismatch flag of the DMR request comparator and decides the system response.

---
 rtl/dmr_fault_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmr_fault_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmr_fault_ctrl.sv
// DMR lockstep fault controller: filters comparator mismatch glitches,
// counts transient and persistent faults, halts both harts on a persistent
// fault, runs the resync handshake and escalates to a sticky fatal state.
module dmr_fault_ctrl #(
    parameter int FILTER_CYC = 2,
    parameter int MAX_FAULTS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dmr_en_i,
    input  logic             error_i,
    input  logic             resync_ack_i,
    input  logic             clear_cnt_i,
    output logic             halt_o,
    output logic             resync_req_o,
    output logic             irq_o,
    output logic             fatal_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] transient_cnt_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    typedef enum logic [2:0] {
        S_NORMAL = 3'd0,
        S_FILTER = 3'd1,
        S_HALT   = 3'd2,
        S_RESYNC = 3'd3,
        S_FATAL  = 3'd4
    } state_t;

    localparam int FW = $clog2(FILTER_CYC + 1);
    localparam int TW = $clog2(MAX_FAULTS + 1);
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_CYC);
    localparam logic [TW-1:0]    TALLY_MAX = TW'(MAX_FAULTS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_reg, state_next;
    logic [FW-1:0]    filt_reg, filt_next;
    // Fault tally that clear_cnt_i cannot touch; it alone decides escalation.
    logic [TW-1:0]    tally_reg;
    logic [CNT_W-1:0] trans_reg;
    logic [CNT_W-1:0] fault_reg;
    logic             halt_reg, req_reg, irq_reg, fatal_reg;
    logic             inc_trans, inc_fault;
    logic             err;

    assign err = error_i & dmr_en_i;

    // Next-state and counter-increment decisions.
    always_comb begin
        state_next = state_reg;
        filt_next  = filt_reg;
        inc_trans  = 1'b0;
        inc_fault  = 1'b0;
        case (state_reg)
            S_NORMAL: begin
                if (err) begin
                    filt_next = FW'(1);
                    if (FILTER_CYC == 1) begin
                        state_next = S_HALT;
                        inc_fault  = 1'b1;
                    end else begin
                        state_next = S_FILTER;
                    end
                end
            end
            S_FILTER: begin
                if (err) begin
                    filt_next = filt_reg + FW'(1);
                    if (filt_next == FILT_LAST) begin
                        state_next = S_HALT;
                        inc_fault  = 1'b1;
                    end
                end else begin
                    // Mismatch vanished (or checking was disabled) before
                    // the filter expired: a glitch, not a fault.
                    inc_trans  = 1'b1;
                    filt_next  = '0;
                    state_next = S_NORMAL;
                end
            end
            S_HALT: begin
                // tally_reg already includes the fault that entered HALT.
                state_next = (tally_reg >= TALLY_MAX) ? S_FATAL : S_RESYNC;
            end
            S_RESYNC: begin
                if (resync_ack_i) begin
                    filt_next  = '0;
                    state_next = S_NORMAL;
                end
            end
            S_FATAL: begin
                state_next = S_FATAL;
            end
            default: begin
                filt_next  = '0;
                state_next = S_NORMAL;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_NORMAL;
            filt_reg  <= '0;
            tally_reg <= '0;
            trans_reg <= '0;
            fault_reg <= '0;
            halt_reg  <= 1'b0;
            req_reg   <= 1'b0;
            irq_reg   <= 1'b0;
            fatal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            filt_reg  <= filt_next;
            if (inc_fault && (tally_reg != TALLY_MAX)) begin
                tally_reg <= tally_reg + TW'(1);
            end
            if (clear_cnt_i) begin
                trans_reg <= '0;
            end else if (inc_trans && (trans_reg != CNT_MAX)) begin
                trans_reg <= trans_reg + CNT_W'(1);
            end
            if (clear_cnt_i) begin
                fault_reg <= '0;
            end else if (inc_fault && (fault_reg != CNT_MAX)) begin
                fault_reg <= fault_reg + CNT_W'(1);
            end
            halt_reg  <= (state_next == S_HALT) || (state_next == S_RESYNC) ||
                         (state_next == S_FATAL);
            req_reg   <= (state_next == S_RESYNC);
            irq_reg   <= (state_next == S_HALT);
            fatal_reg <= (state_next == S_FATAL);
        end
    end

    assign halt_o          = halt_reg;
    assign resync_req_o    = req_reg;
    assign irq_o           = irq_reg;
    assign fatal_o         = fatal_reg;
    assign state_o         = state_reg;
    assign transient_cnt_o = trans_reg;
    assign fault_cnt_o     = fault_reg;

endmodule

// File: tb/tb_dmr_fault_ctrl.sv
// Bench for dmr_fault_ctrl: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
// Two instances share the stimulus: 8-bit and 2-bit counters.
module tb_dmr_fault_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, err = 1'b0, ack = 1'b0, clr = 1'b0;

    logic       halt_a, req_a, irq_a, fatal_a;
    logic [2:0] state_a;
    logic [7:0] trans_a, fault_a;
    logic       halt_b, req_b, irq_b, fatal_b;
    logic [2:0] state_b;
    logic [1:0] trans_b, fault_b;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: state number, consecutive-mismatch run, counts.
    int  m_state = 0;
    int  m_run   = 0;
    int  m_trans = 0;
    int  m_fault = 0;
    int  m_total = 0;
    bit  m_valid = 1'b0;

    localparam int FC  = 2;
    localparam int MAX = 4;

    dmr_fault_ctrl #(.FILTER_CYC(FC), .MAX_FAULTS(MAX), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .dmr_en_i(en), .error_i(err),
        .resync_ack_i(ack), .clear_cnt_i(clr),
        .halt_o(halt_a), .resync_req_o(req_a), .irq_o(irq_a), .fatal_o(fatal_a),
        .state_o(state_a), .transient_cnt_o(trans_a), .fault_cnt_o(fault_a)
    );

    dmr_fault_ctrl #(.FILTER_CYC(FC), .MAX_FAULTS(MAX), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .dmr_en_i(en), .error_i(err),
        .resync_ack_i(ack), .clear_cnt_i(clr),
        .halt_o(halt_b), .resync_req_o(req_b), .irq_o(irq_b), .fatal_o(fatal_b),
        .state_o(state_b), .transient_cnt_o(trans_b), .fault_cnt_o(fault_b)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model, applied to the inputs sampled at that edge.
    task automatic model_step();
        bit e;
        bit t_inc, f_inc;
        e = err & en;
        t_inc = 1'b0;
        f_inc = 1'b0;
        if (rst) begin
            m_state = 0; m_run = 0; m_trans = 0; m_fault = 0; m_total = 0;
        end else begin
            case (m_state)
                0, 1: begin
                    if (e) begin
                        m_run++;
                        if (m_run >= FC) begin
                            m_state = 2;
                            f_inc = 1'b1;
                        end else begin
                            m_state = 1;
                        end
                    end else begin
                        if (m_state == 1) t_inc = 1'b1;
                        m_run = 0;
                        m_state = 0;
                    end
                end
                2: m_state = (m_total >= MAX) ? 4 : 3;
                3: if (ack) begin
                       m_state = 0;
                       m_run = 0;
                   end
                default: m_state = 4;
            endcase
            if (f_inc) begin
                m_total++;
                m_fault++;
            end
            if (t_inc) m_trans++;
            if (clr) begin
                m_trans = 0;
                m_fault = 0;
            end
        end
    endtask

    task automatic cycle(input bit i_en, input bit i_err, input bit i_ack,
                         input bit i_clr, input bit i_rst);
        en = i_en; err = i_err; ack = i_ack; clr = i_clr; rst = i_rst;
        @(posedge clk);
        model_step();
        m_valid = 1'b1;
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",  int'(state_a), m_state);
            chk("halt",   int'(halt_a),  int'(m_state >= 2));
            chk("req",    int'(req_a),   int'(m_state == 3));
            chk("irq",    int'(irq_a),   int'(m_state == 2));
            chk("fatal",  int'(fatal_a), int'(m_state == 4));
            chk("trans8", int'(trans_a), sat(m_trans, 255));
            chk("fault8", int'(fault_a), sat(m_fault, 255));
            chk("state2", int'(state_b), m_state);
            chk("halt2",  int'(halt_b),  int'(m_state >= 2));
            chk("trans2", int'(trans_b), sat(m_trans, 3));
            chk("fault2", int'(fault_b), sat(m_fault, 3));
        end
    end

    initial begin
        // Reset state
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        chk("lit_reset_state", int'(state_a), 0);
        chk("lit_reset_halt", int'(halt_a), 0);
        chk("lit_reset_trans", int'(trans_a), 0);

        // Single-cycle glitch: 0 -> 1 -> 0, one transient, no halt/irq
        cycle(1, 1, 0, 0, 0);
        chk("lit_glitch_filter", int'(state_a), 1);
        cycle(1, 0, 0, 0, 0);
        chk("lit_glitch_back", int'(state_a), 0);
        chk("lit_glitch_trans", int'(trans_a), 1);
        chk("lit_glitch_irq", int'(irq_a), 0);

        // Persistent fault, resync with ack after 5 cycles of request
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("lit_halt_state", int'(state_a), 2);
        chk("lit_halt_irq", int'(irq_a), 1);
        chk("lit_halt_fault", int'(fault_a), 1);
        cycle(1, 0, 0, 0, 0);
        chk("lit_resync_req", int'(req_a), 1);
        chk("lit_resync_irq", int'(irq_a), 0);
        repeat (4) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        chk("lit_ack_state", int'(state_a), 0);
        chk("lit_ack_halt", int'(halt_a), 0);

        // Checking disabled: mismatches ignored
        repeat (10) cycle(0, 1, 0, 0, 0);
        chk("lit_masked_state", int'(state_a), 0);
        chk("lit_masked_trans", int'(trans_a), 1);

        // Clear coincident with a transient: clear wins
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        chk("lit_clr_trans", int'(trans_a), 0);
        chk("lit_clr_fault", int'(fault_a), 0);

        // Three more faults: the fourth in total escalates despite the clear
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0);
            cycle(1, 1, 0, 0, 0);
            cycle(1, 0, 0, 0, 0);
            if (i < 2) cycle(1, 0, 1, 0, 0);
        end
        chk("lit_fatal_state", int'(state_a), 4);
        chk("lit_fatal_flag", int'(fatal_a), 1);
        chk("lit_fatal_req", int'(req_a), 0);
        chk("lit_fatal_fault", int'(fault_a), 3);
        repeat (3) cycle(1, 1, 1, 0, 0);
        chk("lit_fatal_sticky", int'(state_a), 4);

        // Reset while in RESYNC
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("lit_pre_rst_state", int'(state_a), 3);
        cycle(1, 0, 0, 0, 1);
        chk("lit_rst_state", int'(state_a), 0);
        chk("lit_rst_halt", int'(halt_a), 0);
        chk("lit_rst_fault", int'(fault_a), 0);

        // Five transients: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 0, 0);
            cycle(1, 0, 0, 0, 0);
        end
        chk("lit_sat_trans2", int'(trans_b), 3);
        chk("lit_sat_trans8", int'(trans_a), 5);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 16) != 0,
                  ($urandom % 3) == 0,
                  ($urandom % 4) == 0,
                  ($urandom % 64) == 0,
                  ($urandom % 150) == 0);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
